// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU: operation codes, FSM states and the
// instruction decoder. decode_op is the only place the {funct7,funct3,ALUOp}
// encodings live; every other file goes through it.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_NOP = 3'b011,
        OP_AND = 3'b100,
        OP_XOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // key = {funct7[6:0], funct3[2:0], ALUOp[2:0]}
    function automatic op_e decode_op(input logic [12:0] key);
        op_e op;
        op = OP_NOP;
        casez (key)
            13'b???????_000_001,                 // addi
            13'b???????_010_000,                 // lw
            13'b???????_010_010,                 // sw
            13'b0000000_000_011: op = OP_ADD;    // add
            13'b0100000_000_011,                 // sub
            13'b???????_000_110: op = OP_SUB;    // beq
            13'b0000001_000_011: op = OP_MUL;    // mul
            13'b0000000_111_011: op = OP_AND;    // and
            13'b0000000_100_011: op = OP_XOR;    // xor
            13'b0000000_001_011: op = OP_SLL;    // sll
            13'b0100000_101_001: op = OP_SRA;    // srai
            default:             op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low XLEN bits of op_a*op_b.
// Latency: XLEN/MUL_BITS_PER_CYCLE iterations after start; last flags the final one.
// Backpressure: none; start is only honoured by the caller when idle, clr aborts at once.
// Ports: clk, rst_n (sync active-low), clr (sync abort), start, op_a, op_b,
//        last (this cycle retires the final bits), product (accumulator after this cycle).
module alu_mul_iter #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            last,
    output logic [XLEN-1:0] product
);
    import alu_pkg::*;

    localparam int N  = XLEN / MUL_BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;     // multiplicand, pre-shifted to the current bit position
    logic [XLEN-1:0] mplier;    // multiplier, consumed from the LSB end
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] partial;

    // Sum of the shifted multiplicand for each multiplier bit retired this cycle.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    assign product = acc + partial;
    assign last    = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= CW'(N);
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << MUL_BITS_PER_CYCLE;
            mplier <= mplier >> MUL_BITS_PER_CYCLE;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_decode_exec.sv
// EX-stage ALU: decodes {funct7,funct3,ALUOp} and executes; single-cycle ops, iterative MUL.
// Latency: 1 cycle for single-cycle ops, XLEN/MUL_BITS_PER_CYCLE+1 for MUL.
// Backpressure: ready_o low while MUL iterates (busy_o stalls upstream); flush_i kills work.
// Ports: clk_i, rst_i (sync active-low), flush_i, valid_i/ready_o issue handshake,
//        ALUOp_i/funct7_i/funct3_i decode key, src1_i/src2_i operands,
//        valid_o/result_o/zero_o result pulse, busy_o stall request.
module alu_decode_exec #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      ALUOp_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            busy_o
);
    import alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    op_e             op;
    logic            issue;
    logic            mul_start;
    logic            mul_last;
    logic            mul_finish;
    logic            load_sc;
    logic [XLEN-1:0] mul_prod;
    logic [XLEN-1:0] sc_res;
    logic [SHW-1:0]  shamt;
    logic            vld_q;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [XLEN-1:0] res_d;

    assign op    = decode_op({funct7_i, funct3_i, ALUOp_i});
    assign shamt = src2_i[SHW-1:0];

    // DONE hands its result out and accepts the next op in the same cycle,
    // so only the iterating state refuses issue.
    assign ready_o = (state_q != ST_MUL);
    assign busy_o  = (state_q != ST_IDLE);
    assign issue   = valid_i && ready_o && !flush_i;

    always_comb begin
        sc_res = '0;
        case (op)
            OP_ADD:  sc_res = src1_i + src2_i;
            OP_SUB:  sc_res = src1_i - src2_i;
            OP_AND:  sc_res = src1_i & src2_i;
            OP_XOR:  sc_res = src1_i ^ src2_i;
            OP_SLL:  sc_res = src1_i << shamt;
            OP_SRA:  sc_res = $unsigned($signed(src1_i) >>> shamt);
            default: sc_res = '0;   // NOP, and MUL is produced by the multiplier
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        load_sc   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (issue) begin
                    if (op == OP_MUL) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end else begin
                        load_sc = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (mul_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mul_finish = (state_q == ST_MUL) && mul_last && !flush_i;
    assign res_d      = load_sc ? sc_res : mul_prod;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= load_sc || mul_finish;
            if (load_sc || mul_finish) begin
                res_q  <= res_d;
                zero_q <= (res_d == '0);
            end
        end
    end

    // The MUL result is already registered when DONE is entered; a flush
    // arriving during DONE still has to swallow the pulse.
    assign valid_o  = vld_q && !((state_q == ST_DONE) && flush_i);
    assign result_o = res_q;
    assign zero_o   = zero_q && valid_o;

    alu_mul_iter #(
        .XLEN               (XLEN),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clr     (flush_i),
        .start   (mul_start),
        .op_a    (src1_i),
        .op_b    (src2_i),
        .last    (mul_last),
        .product (mul_prod)
    );

endmodule

// File: tb/tb_alu_decode_exec.sv
// Directed bench for alu_decode_exec: hand-computed vectors, one check task.
// A second instance with MUL_BITS_PER_CYCLE=4 shares the stimulus for the MUL latency case.
// Time is counted in cycles after the issuing clock edge; outputs sampled 1ns after posedge.
module tb_alu_decode_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        vin = 1'b0;
    logic [2:0]  aluop = '0;
    logic [6:0]  f7 = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        rdy, vout, zero, busy;
    logic [31:0] res;
    logic        rdy4, vout4, zero4, busy4;
    logic [31:0] res4;

    int n_chk = 0;
    int n_ok  = 0;

    always #5 clk = ~clk;

    alu_decode_exec #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(rdy),
        .ALUOp_i(aluop), .funct7_i(f7), .funct3_i(f3), .src1_i(a), .src2_i(b),
        .valid_o(vout), .result_o(res), .zero_o(zero), .busy_o(busy)
    );

    alu_decode_exec #(.XLEN(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(rdy4),
        .ALUOp_i(aluop), .funct7_i(f7), .funct3_i(f3), .src1_i(a), .src2_i(b),
        .valid_o(vout4), .result_o(res4), .zero_o(zero4), .busy_o(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_ok++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] t7, input logic [2:0] t3, input logic [2:0] top,
                         input logic [31:0] ta, input logic [31:0] tb);
        f7 = t7; f3 = t3; aluop = top; a = ta; b = tb; vin = 1'b1;
    endtask

    task automatic count_valids(input int ncyc, output int cnt);
        cnt = 0;
        repeat (ncyc) begin
            tick();
            if (vout) cnt++;
        end
    endtask

    typedef struct {
        logic [6:0]  t7;
        logic [2:0]  t3;
        logic [2:0]  top;
        logic [31:0] ta;
        logic [31:0] tb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        int bad;

        vecs[0] = '{7'b1010101, 3'b000, 3'b001, 32'd10,        32'hFFFF_FFFF, 32'd9};          // addi
        vecs[1] = '{7'b0000000, 3'b010, 3'b000, 32'h1000,      32'h24,        32'h1024};       // lw
        vecs[2] = '{7'b1111111, 3'b010, 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0};          // sw wrap
        vecs[3] = '{7'b0011001, 3'b000, 3'b110, 32'd7,         32'd9,         32'hFFFF_FFFE};  // beq
        vecs[4] = '{7'b0000000, 3'b111, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};  // and
        vecs[5] = '{7'b0000000, 3'b100, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};  // xor
        vecs[6] = '{7'b0000000, 3'b001, 3'b011, 32'd3,         32'h25,        32'h60};         // sll by 5
        vecs[7] = '{7'b0100000, 3'b101, 3'b001, 32'h4000_0000, 32'h21,        32'h2000_0000};  // srai by 1
        vecs[8] = '{7'b0000000, 3'b101, 3'b001, 32'h4000_0000, 32'h1,         32'd0};          // not srai -> NOP

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'd0, vout}, 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, rdy}, 32'd1);
        rst = 1'b1;

        // Back-to-back add, sub, srai
        drive(7'b0000000, 3'b000, 3'b011, 32'd5, 32'd7);
        tick();
        chk("add_valid", {31'd0, vout}, 32'd1);
        chk("add_result", res, 32'd12);
        chk("add_zero", {31'd0, zero}, 32'd0);
        chk("add_ready", {31'd0, rdy}, 32'd1);
        drive(7'b0100000, 3'b000, 3'b011, 32'd3, 32'd3);
        tick();
        chk("sub_valid", {31'd0, vout}, 32'd1);
        chk("sub_result", res, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        chk("sub_ready", {31'd0, rdy}, 32'd1);
        drive(7'b0100000, 3'b101, 3'b001, 32'h8000_0000, 32'd4);
        tick();
        chk("srai_valid", {31'd0, vout}, 32'd1);
        chk("srai_result", res, 32'hF800_0000);
        chk("srai_ready", {31'd0, rdy}, 32'd1);
        vin = 1'b0;
        tick();
        chk("idle_valid", {31'd0, vout}, 32'd0);
        chk("idle_hold", res, 32'hF800_0000);

        // Decode table, issued back to back
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].t7, vecs[i].t3, vecs[i].top, vecs[i].ta, vecs[i].tb);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, vout}, 32'd1);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
        end
        chk("sw_wrap_zero", {31'd0, zero}, 32'd1);   // last vector is NOP -> 0
        vin = 1'b0;
        tick();

        // MUL latency, both multiplier widths
        drive(7'b0000001, 3'b000, 3'b011, 32'h0001_0003, 32'h0000_0010);
        tick();
        vin = 1'b0;
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (!(rdy == 1'b0 && busy == 1'b1 && vout == 1'b0)) bad++;
            if (k == 8) chk("mul4_c8_valid", {31'd0, vout4}, 32'd0);
            if (k == 9) begin
                chk("mul4_c9_valid", {31'd0, vout4}, 32'd1);
                chk("mul4_c9_result", res4, 32'h0010_0030);
            end
            tick();
        end
        chk("mul_stall_cycles_bad", bad, 0);
        chk("mul_c33_valid", {31'd0, vout}, 32'd1);
        chk("mul_c33_result", res, 32'h0010_0030);
        chk("mul_c33_zero", {31'd0, zero}, 32'd0);
        chk("mul_c33_ready", {31'd0, rdy}, 32'd1);
        tick();
        chk("mul_c34_valid", {31'd0, vout}, 32'd0);
        chk("mul_c34_busy", {31'd0, busy}, 32'd0);

        // MUL wrap
        drive(7'b0000001, 3'b000, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        vin = 1'b0;
        n = 0;
        while (!vout && n < 40) begin
            tick();
            n++;
        end
        chk("mulwrap_latency", n, 32);
        chk("mulwrap_result", res, 32'h0000_0001);
        tick();

        // Flush mid-MUL at cycle 10
        drive(7'b0000001, 3'b000, 3'b011, 32'd6, 32'd7);
        tick();
        vin = 1'b0;
        repeat (9) tick();
        chk("flush_c10_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_c11_ready", {31'd0, rdy}, 32'd1);
        chk("flush_c11_busy", {31'd0, busy}, 32'd0);
        chk("flush_c11_valid", {31'd0, vout}, 32'd0);
        count_valids(40, n);
        chk("flush_mul_no_valid", n, 0);

        // Flush on issue of a single-cycle op
        drive(7'b0000000, 3'b000, 3'b011, 32'd1, 32'd2);
        flush = 1'b1;
        tick();
        vin = 1'b0;
        flush = 1'b0;
        chk("flush_add_valid", {31'd0, vout}, 32'd0);
        count_valids(3, n);
        chk("flush_add_no_valid", n, 0);

        // Held issue during MUL is accepted once when ready returns
        drive(7'b0000001, 3'b000, 3'b011, 32'd3, 32'd5);
        tick();
        drive(7'b0000000, 3'b000, 3'b011, 32'd5, 32'd7);
        n = 0;
        while (!rdy && n < 40) begin
            tick();
            n++;
        end
        chk("stall_wait", n, 32);
        chk("stall_mul_valid", {31'd0, vout}, 32'd1);
        chk("stall_mul_result", res, 32'd15);
        tick();
        vin = 1'b0;
        chk("stall_add_valid", {31'd0, vout}, 32'd1);
        chk("stall_add_result", res, 32'd12);
        count_valids(5, n);
        chk("stall_add_once", n, 0);

        // Unknown key -> NOP result 0 with a valid pulse
        drive(7'b0000000, 3'b110, 3'b011, 32'd5, 32'd7);
        tick();
        vin = 1'b0;
        chk("nop_valid", {31'd0, vout}, 32'd1);
        chk("nop_result", res, 32'd0);
        chk("nop_zero", {31'd0, zero}, 32'd1);

        // Reset mid-MUL at cycle 5
        drive(7'b0000000, 3'b000, 3'b011, 32'd5, 32'd7);
        tick();
        chk("pre_rst_result", res, 32'd12);
        drive(7'b0000001, 3'b000, 3'b011, 32'h0001_0003, 32'h0000_0010);
        tick();
        vin = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, vout}, 32'd0);
        chk("midrst_result", res, 32'd0);
        chk("midrst_ready", {31'd0, rdy}, 32'd1);
        rst = 1'b1;
        count_valids(40, n);
        chk("midrst_no_late_valid", n, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
